// File: rtl/k6502_oam_dma_pkg.sv
// k6502_oam_dma_pkg: state encodings and default register addresses for the sprite DMA controller
package k6502_oam_dma_pkg;
  localparam int DMA_STATE_BITS = 3;
  typedef enum logic [DMA_STATE_BITS-1:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_e;
  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
endpackage

// File: rtl/k6502_oam_dma.sv
// k6502_oam_dma: sprite DMA controller and bus arbiter copying one 256-byte page to OAM; K6502_DMA_DEBUG_EN adds dbg_state/dbg_idx ports
module k6502_oam_dma
  import k6502_oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        bus_sel,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_rw
`ifdef K6502_DMA_DEBUG_EN
  ,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_idx
`endif
);
  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d, idx_q, idx_d, data_q, data_d, bus_dout_q, bus_dout_d;
  logic [15:0] bus_a_q, bus_a_d;
  logic        parity_q, parity_d;
  // next-state logic; bus address/data are registered from the next state so they hold outside bus cycles
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = ~parity_q;
    case (state_q)
      DMA_IDLE:
        if (!cpu_rw && cpu_a == DMA_REG_ADDR) begin
          page_d  = cpu_dout;
          idx_d   = '0;
          state_d = DMA_HALT;
        end
      DMA_HALT:  if (cpu_rw) state_d = parity_q ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        data_d  = bus_din;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = idx_q == 8'hFF ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
    bus_a_d    = state_d == DMA_ALIGN ? {page_d, 8'h00} :
                 state_d == DMA_READ  ? {page_d, idx_d} :
                 state_d == DMA_WRITE ? OAM_DATA_ADDR   : bus_a_q;
    bus_dout_d = state_d == DMA_WRITE ? data_d : bus_dout_q;
  end
  // state, counters and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= DMA_IDLE;
      page_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bus_a_q    <= '0;
      bus_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      bus_a_q    <= bus_a_d;
      bus_dout_q <= bus_dout_d;
    end
  end
  assign rdy      = state_q == DMA_IDLE;
  assign bus_sel  = state_q == DMA_ALIGN || state_q == DMA_READ || state_q == DMA_WRITE;
  assign bus_rw   = state_q != DMA_WRITE;
  assign bus_a    = bus_a_q;
  assign bus_dout = bus_dout_q;
`ifdef K6502_DMA_DEBUG_EN
  assign dbg_state = state_q;
  assign dbg_idx   = idx_q;
`endif
endmodule

// File: tb/tb_k6502_oam_dma.sv
// tb_k6502_oam_dma: randomized directed bench for the sprite DMA controller against a transfer-level model
module tb_k6502_oam_dma;
  logic        clk = 1'b0, rst_n = 1'b0, cpu_rw = 1'b1;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  bus_din;
  logic        rdy, bus_sel, bus_rw;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic [7:0]  mem [0:65535];
  int          tests = 0, fails = 0;
  bit          par_m = 1'b0;
  localparam logic [15:0] DMA_A = 16'h4014, OAM_A = 16'h2004;

  k6502_oam_dma dut (
    .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
    .bus_din(bus_din), .rdy(rdy), .bus_sel(bus_sel), .bus_a(bus_a),
    .bus_dout(bus_dout), .bus_rw(bus_rw)
  );

  always #5 clk = ~clk;
  assign bus_din = mem[bus_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; the model parity restarts at 0 on a reset edge and toggles otherwise
  task automatic tick;
    @(posedge clk);
    #1;
    par_m = rst_n ? ~par_m : 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rdy"}, rdy, 1);
    chk({tag, ".sel"}, bus_sel, 0);
    chk({tag, ".rw"}, bus_rw, 1);
  endtask

  // one DMA from trigger to completion; align selects whether the HALT exit lands on parity 0
  task automatic run_dma(input logic [7:0] pg, input int hold, input bit align, input int abort_at, input bit poke);
    int stall = 0;
    bit do_align;
    if ((par_m ^ bit'((hold + 1) % 2)) == align) tick;
    cpu_a = DMA_A; cpu_dout = pg; cpu_rw = 1'b0;
    tick;
    for (int h = 0; h < hold; h++) begin
      cpu_a = 16'h01FD; cpu_dout = 8'($urandom); cpu_rw = 1'b0;
      chk("halt.rdy", rdy, 0);
      chk("halt.sel", bus_sel, 0);
      stall += int'(!rdy);
      tick;
    end
    cpu_rw = 1'b1; cpu_a = 16'h8000;
    do_align = !par_m;
    chk("halt.rdy", rdy, 0);
    chk("halt.sel", bus_sel, 0);
    stall += int'(!rdy);
    tick;
    if (do_align) begin
      chk("align.sel", bus_sel, 1);
      chk("align.rw", bus_rw, 1);
      chk("align.a", bus_a, {pg, 8'h00});
      stall += int'(!rdy);
      tick;
    end
    for (int k = 0; k < 256; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk_idle("abort");
        chk("abort.a", bus_a, 0);
        chk("abort.dout", bus_dout, 0);
        return;
      end
      chk("read.sel", bus_sel, 1);
      chk("read.rw", bus_rw, 1);
      chk("read.a", bus_a, {pg, 8'(k)});
      stall += int'(!rdy);
      if (poke && k == 3) begin
        cpu_rw = 1'b0; cpu_a = DMA_A; cpu_dout = 8'h05;
      end
      tick;
      cpu_rw = 1'b1; cpu_a = 16'h8000;
      chk("write.sel", bus_sel, 1);
      chk("write.rw", bus_rw, 0);
      chk("write.a", bus_a, OAM_A);
      chk("write.dout", bus_dout, mem[{pg, 8'(k)}]);
      stall += int'(!rdy);
      tick;
    end
    chk_idle("done");
    chk("done.a_hold", bus_a, OAM_A);
    chk("done.dout_hold", bus_dout, mem[{pg, 8'hFF}]);
    chk("stall_len", stall, 513 + hold + int'(do_align));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0;
    tick;
    tick;
    chk_idle("reset");
    chk("reset.a", bus_a, 0);
    chk("reset.dout", bus_dout, 0);
    rst_n = 1'b1;
    tick;
    run_dma(8'h02, 0, 1'b0, -1, 1'b0);
    tick;
    run_dma(8'h02, 0, 1'b1, -1, 1'b0);
    tick;
    run_dma(8'($urandom), 2, 1'($urandom), -1, 1'b0);
    run_dma(8'hFF, 0, 1'($urandom), -1, 1'b0);
    run_dma(8'($urandom), 0, 1'($urandom), 8'h40, 1'b0);
    run_dma(8'($urandom), 1, 1'($urandom), -1, 1'b0);
    cpu_a = 16'h4015; cpu_dout = 8'h05; cpu_rw = 1'b0;
    tick;
    cpu_rw = 1'b1; cpu_a = 16'h8000;
    chk_idle("nontrig");
    tick;
    chk_idle("nontrig2");
    run_dma(8'($urandom), 0, 1'($urandom), -1, 1'b1);
    for (int r = 0; r < 3; r++) run_dma(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
